// File: rtl/echo_frame_sequencer_if.sv
// Handshake bundle between the echo frame sequencer and its conversion/adaptation stages.
// master: the sequencer; slave: the stage side (converters, lag, para_approx, echo_cancelation).
interface echo_frame_sequencer_if #(
  parameter int CYCLE_W = 13,
  parameter int ITER_W  = 11
);
  logic                run;
  logic [ITER_W-1:0]   set_max_iteration;
  logic                ready_conv;
  logic                ready_lag;
  logic                ready_para;
  logic                ready_cancel;
  logic [CYCLE_W-1:0]  sampling_cycle_counter;
  logic                sampling_light;
  logic                enable_conv;
  logic                enable_lag;
  logic                enable_para;
  logic                enable_cancel;
  logic                enable_sampling;
  logic                out_load;
  logic                out_sel;
  logic                mode_cancel;
  logic [ITER_W-1:0]   iteration;
  logic                timeout_err;
  logic                overrun_err;
  logic [CYCLE_W-1:0]  frame_latency;

  modport master (
    input  run, set_max_iteration, ready_conv, ready_lag, ready_para, ready_cancel,
    output sampling_cycle_counter, sampling_light, enable_conv, enable_lag, enable_para,
           enable_cancel, enable_sampling, out_load, out_sel, mode_cancel, iteration,
           timeout_err, overrun_err, frame_latency
  );

  modport slave (
    output run, set_max_iteration, ready_conv, ready_lag, ready_para, ready_cancel,
    input  sampling_cycle_counter, sampling_light, enable_conv, enable_lag, enable_para,
           enable_cancel, enable_sampling, out_load, out_sel, mode_cancel, iteration,
           timeout_err, overrun_err, frame_latency
  );
endinterface

// File: rtl/echo_frame_sequencer.sv
// Per-sample controller: frame counter plus conv -> lag -> para/cancel -> load sequence on ready edges.
// Optional macro FRAME_STATS_EN: frame_latency captures the frame counter at every output load.
module echo_frame_sequencer #(
  parameter int CYCLE_W        = 13,
  parameter int SAMPLING_CYCLE = 4000,
  parameter int ITER_W         = 11,
  parameter int PULSE_LEN      = 2,
  parameter int TIMEOUT        = 1023
) (
  input logic                    clk_operation,
  input logic                    rst,
  echo_frame_sequencer_if.master seq
);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CYCLE_W-1:0] LAST = CYCLE_W'(SAMPLING_CYCLE - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CONV_P = 4'd1;
  localparam logic [3:0] S_CONV_W = 4'd2;
  localparam logic [3:0] S_LAG_P  = 4'd3;
  localparam logic [3:0] S_LAG_W  = 4'd4;
  localparam logic [3:0] S_PROC_P = 4'd5;
  localparam logic [3:0] S_PROC_W = 4'd6;
  localparam logic [3:0] S_LOAD   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]         r_state;
  logic [CYCLE_W-1:0] r_cnt;
  logic               r_light;
  logic [PW-1:0]      r_pulse;
  logic [TW-1:0]      r_wait;
  logic               r_rdy_q;
  logic               r_seen;
  logic [ITER_W-1:0]  r_iter;
  logic               r_mode;
  logic               r_to;
  logic               r_ov;
  logic               r_samp;

  logic [3:0] w_next;
  logic       w_wrap, w_rest, w_ovr, w_is_p, w_is_w, w_rdy, w_rise;
  logic       w_pulse_end, w_go, w_tmo, w_restart, w_enter_p;

  function automatic logic is_pulse(input logic [3:0] s);
    return (s == S_CONV_P) || (s == S_LAG_P) || (s == S_PROC_P);
  endfunction

  assign w_wrap = (r_cnt == LAST);
  assign w_rest = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_ovr  = w_wrap && !w_rest;
  assign w_is_p = is_pulse(r_state);
  assign w_is_w = (r_state == S_CONV_W) || (r_state == S_LAG_W) || (r_state == S_PROC_W);

  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      S_CONV_P, S_CONV_W: w_rdy = seq.ready_conv;
      S_LAG_P,  S_LAG_W:  w_rdy = seq.ready_lag;
      S_PROC_P, S_PROC_W: w_rdy = r_mode ? seq.ready_cancel : seq.ready_para;
      default:            w_rdy = 1'b0;
    endcase
  end

  // r_rdy_q is forced high on pulse entry so a ready already high at pulse start is not an edge.
  assign w_rise      = w_rdy && !r_rdy_q;
  assign w_pulse_end = w_is_p && (r_pulse == PW'(PULSE_LEN - 1));
  assign w_go        = r_seen || w_rise;
  assign w_tmo       = w_is_w && !w_go && (r_wait == TW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_wrap) w_next = seq.run ? S_CONV_P : S_IDLE;
      S_CONV_P:       if (w_pulse_end) w_next = S_CONV_W;
      S_CONV_W:       if (w_go) w_next = S_LAG_P;  else if (w_tmo) w_next = S_DONE;
      S_LAG_P:        if (w_pulse_end) w_next = S_LAG_W;
      S_LAG_W:        if (w_go) w_next = S_PROC_P; else if (w_tmo) w_next = S_DONE;
      S_PROC_P:       if (w_pulse_end) w_next = S_PROC_W;
      S_PROC_W:       if (w_go) w_next = S_LOAD;   else if (w_tmo) w_next = S_DONE;
      S_LOAD:         w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
    if (w_ovr) w_next = S_CONV_P;
  end

  assign w_restart = (w_next != r_state) || w_ovr;
  assign w_enter_p = w_restart && is_pulse(w_next);

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_light <= 1'b0;
      r_pulse <= '0;
      r_wait  <= '0;
      r_rdy_q <= 1'b0;
      r_seen  <= 1'b0;
      r_iter  <= '0;
      r_mode  <= 1'b0;
      r_to    <= 1'b0;
      r_ov    <= 1'b0;
      r_samp  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_wrap ? '0 : r_cnt + CYCLE_W'(1);
      r_light <= w_wrap;
      if (w_restart)   r_pulse <= '0;
      else if (w_is_p) r_pulse <= r_pulse + PW'(1);
      if (w_restart)   r_wait <= '0;
      else if (w_is_w) r_wait <= r_wait + TW'(1);
      r_rdy_q <= w_enter_p ? 1'b1 : w_rdy;
      r_seen  <= w_enter_p ? 1'b0 : (r_seen || (w_rise && (w_is_p || w_is_w)));
      if ((r_state == S_LOAD) && !w_ovr) begin
        r_samp <= 1'b1;
        if (!r_mode && (r_iter != '1)) r_iter <= r_iter + ITER_W'(1);
      end
      if (w_rest && (r_iter >= seq.set_max_iteration)) r_mode <= 1'b1;
      if (w_tmo) r_to <= 1'b1;
      if (w_ovr) r_ov <= 1'b1;
    end
  end

`ifdef FRAME_STATS_EN
  logic [CYCLE_W-1:0] r_lat;
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst)                    r_lat <= '0;
    else if (r_state == S_LOAD)  r_lat <= r_cnt;
  end
  assign seq.frame_latency = r_lat;
`else
  assign seq.frame_latency = '0;
`endif

  assign seq.sampling_cycle_counter = r_cnt;
  assign seq.sampling_light         = r_light;
  assign seq.enable_conv            = (r_state == S_CONV_P);
  assign seq.enable_lag             = (r_state == S_LAG_P);
  assign seq.enable_para            = (r_state == S_PROC_P) && !r_mode;
  assign seq.enable_cancel          = (r_state == S_PROC_P) && r_mode;
  assign seq.enable_sampling        = r_samp;
  assign seq.out_load               = (r_state == S_LOAD);
  assign seq.out_sel                = r_mode;
  assign seq.mode_cancel            = r_mode;
  assign seq.iteration              = r_iter;
  assign seq.timeout_err            = r_to;
  assign seq.overrun_err            = r_ov;
endmodule
